// File: rtl/max7219_chain_master.sv
// rtl/max7219_chain_master.sv - SPI write master for a daisy chain of MAX7219 drivers
//
// Sends one N_DEV*16-bit chain word per accepted start, MSB first. The first
// 16 bits reach the far end of the chain (device N_DEV-1) and the last 16 bits
// stay in device 0. Devices that are not addressed get a NO-OP (16'h0000) slot.
//
// Ports:
//   sck        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   start      in   request one chain write (sampled only while busy=0)
//   broadcast  in   1: every device gets {address,data}; 0: only dev_sel
//   dev_sel    in   target device index, 0 = nearest to mosi
//   address    in   MAX7219 register address
//   data       in   MAX7219 register data
//   busy       out  high while a frame is in progress
//   finish     out  one-cycle pulse in the last cycle of a frame
//   mosi       out  serial data to DIN of device 0
//   spi_clk    out  SPI clock, idles low
//   cs         out  LOAD/CS, active low, idles high

module max7219_chain_master #(
  parameter int N_DEV   = 4,
  parameter int CLK_DIV = 4,
  localparam int DEV_W  = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
  input  logic             sck,
  input  logic             rst_n,
  input  logic             start,
  input  logic             broadcast,
  input  logic [DEV_W-1:0] dev_sel,
  input  logic [7:0]       address,
  input  logic [7:0]       data,
  output logic             busy,
  output logic             finish,
  output logic             mosi,
  output logic             spi_clk,
  output logic             cs
);

  localparam int W       = N_DEV * 16;
  localparam int CNT_W   = $clog2(W + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIV_PEN = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PENUL = DIV_W'(DIV_PEN);
  localparam logic [CNT_W-1:0] BITS      = CNT_W'(W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    LATCH
  } state_t;

  state_t             state_q;
  logic [W-1:0]       sr_q;
  logic [W-1:0]       word_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [DIV_W-1:0]   div_q;
  logic               cs_q;
  logic               spi_clk_q;
  logic               mosi_q;
  logic               busy_q;
  logic               finish_q;

  // Chain word: slot i occupies bits [i*16 +: 16], so device 0 is shifted last.
  // An out-of-range dev_sel matches no slot and yields an all-NO-OP frame.
  always_comb begin
    word_d = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (broadcast || (32'(dev_sel) == i)) begin
        word_d[i*16 +: 16] = {address, data};
      end
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      cs_q      <= 1'b1;
      spi_clk_q <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cs_q      <= 1'b1;
          spi_clk_q <= 1'b0;
          mosi_q    <= 1'b0;
          finish_q  <= 1'b0;
          if (start && !busy_q) begin
            state_q   <= SHIFT;
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
            mosi_q    <= word_d[W-1];
            sr_q      <= word_d << 1;
            bit_cnt_q <= '0;
            div_q     <= '0;
          end
        end

        // spi_clk_q doubles as the half-bit phase: low half then high half.
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!spi_clk_q) begin
              spi_clk_q <= 1'b1;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else begin
              spi_clk_q <= 1'b0;
              if (bit_cnt_q == BITS) begin
                state_q <= HOLD;
                mosi_q  <= 1'b0;
              end else begin
                mosi_q <= sr_q[W-1];
                sr_q   <= sr_q << 1;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        HOLD: begin
          if (div_q == DIV_LAST) begin
            div_q    <= '0;
            state_q  <= LATCH;
            cs_q     <= 1'b1;
            // A one-cycle LATCH is already its own last cycle.
            finish_q <= (CLK_DIV == 1);
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        LATCH: begin
          if (div_q == DIV_LAST) begin
            div_q    <= '0;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
          end else begin
            div_q    <= div_q + DIV_W'(1);
            finish_q <= (div_q == DIV_PENUL);
          end
        end

        default: begin
          state_q   <= IDLE;
          cs_q      <= 1'b1;
          spi_clk_q <= 1'b0;
          mosi_q    <= 1'b0;
          busy_q    <= 1'b0;
          finish_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign finish  = finish_q;
  assign mosi    = mosi_q;
  assign spi_clk = spi_clk_q;
  assign cs      = cs_q;

endmodule

// File: tb/tb_max7219_chain_master.sv
// tb/tb_max7219_chain_master.sv - self-checking bench for max7219_chain_master
module tb_max7219_chain_master;

  localparam int N        = 3;
  localparam int D        = 2;
  localparam int DW       = 2;
  localparam int W        = N * 16;
  localparam int BUSY_LEN = N * 32 * D + 2 * D;
  localparam int CS_LOW   = N * 32 * D + D;

  logic          sck = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          broadcast = 1'b0;
  logic [DW-1:0] dev_sel = '0;
  logic [7:0]    address = '0;
  logic [7:0]    data = '0;
  logic          busy, finish, mosi, spi_clk, cs;

  int checks = 0;
  int failures = 0;

  always #5 sck = ~sck;

  max7219_chain_master #(.N_DEV(N), .CLK_DIV(D)) dut (
    .sck       (sck),
    .rst_n     (rst_n),
    .start     (start),
    .broadcast (broadcast),
    .dev_sel   (dev_sel),
    .address   (address),
    .data      (data),
    .busy      (busy),
    .finish    (finish),
    .mosi      (mosi),
    .spi_clk   (spi_clk),
    .cs        (cs)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference chain word: device dv's slot is the dv-th 16-bit group from the
  // end of the serial stream.
  function automatic logic [W-1:0] model(input bit bc, input int sel, input int a, input int d);
    logic [W-1:0] m = '0;
    for (int dv = 0; dv < N; dv++) begin
      if (bc || sel == dv) m[dv*16 +: 16] = {a[7:0], d[7:0]};
    end
    return m;
  endfunction

  // Idle-line watcher: mosi must be 0 whenever cs is high, and every cs fall
  // must follow at least D cycles of cs high.
  logic prev_cs = 1'b1;
  int   hi_run = 0;
  always @(negedge sck) begin
    if (cs === 1'b1) begin
      check("mosi_when_cs_high", mosi, 0);
      hi_run++;
    end else begin
      if (prev_cs === 1'b1) check("cs_high_gap_ge_div", (hi_run >= D), 1);
      hi_run = 0;
    end
    prev_cs = cs;
  end

  // Called at a negedge; start is raised immediately so consecutive calls
  // issue the next request in the cycle right after busy falls.
  task automatic run_frame(input bit bc, input int sel, input int a, input int d,
                           input bit mid_pulse, input bit fin_pulse);
    logic [W-1:0] exp;
    logic [W-1:0] cap = '0;
    int  rises = 0, busy_cnt = 0, cs_low = 0, fin_cnt = 0, fin_idx = 0, clk_hi = 0;
    bit  prev_clk = 1'b0;
    bit  done = 1'b0;
    exp       = model(bc, sel, a, d);
    broadcast = bc;
    dev_sel   = sel[DW-1:0];
    address   = a[7:0];
    data      = d[7:0];
    start     = 1'b1;
    @(posedge sck);
    #1;
    start     = 1'b0;
    broadcast = 1'($urandom);
    dev_sel   = DW'($urandom);
    address   = 8'($urandom);
    data      = 8'($urandom);
    for (int k = 1; k <= BUSY_LEN + 20 && !done; k++) begin
      @(negedge sck);
      if (k == 1) begin
        check("entry_cs_low", cs, 0);
        check("entry_busy", busy, 1);
      end
      if (mid_pulse) start = (k == 50);
      if (busy) busy_cnt++;
      else done = 1'b1;
      if (!cs) cs_low++;
      if (finish) begin
        fin_cnt++;
        fin_idx = k;
        if (fin_pulse) start = 1'b1;
      end
      if (spi_clk) clk_hi++;
      if (spi_clk && !prev_clk) begin
        cap = {cap[W-2:0], mosi};
        rises++;
      end
      prev_clk = spi_clk;
    end
    start = 1'b0;
    check("frame_completed", done, 1);
    check("chain_word", cap, exp);
    check("spi_clk_rises", rises, W);
    check("spi_clk_high_cycles", clk_hi, W * D);
    check("busy_cycles", busy_cnt, BUSY_LEN);
    check("cs_low_cycles", cs_low, CS_LOW);
    check("finish_pulses", fin_cnt, 1);
    check("finish_cycle", fin_idx, BUSY_LEN);
  endtask

  initial begin
    int rises;
    bit pclk;

    repeat (3) @(negedge sck);
    check("rst_cs", cs, 1);
    check("rst_spi_clk", spi_clk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sck);
    check("idle_busy", busy, 0);
    check("idle_cs", cs, 1);

    // Directed: single device, broadcast, out-of-range select.
    run_frame(1'b0, 1, 8'h01, 8'h55, 1'b0, 1'b0);
    run_frame(1'b1, 0, 8'h0C, 8'h01, 1'b0, 1'b0);
    run_frame(1'b0, 3, 8'hAA, 8'h0A, 1'b0, 1'b0);

    // Starts mid-frame and in the finish cycle are dropped.
    run_frame(1'b0, 0, 8'h0F, 8'hF0, 1'b1, 1'b1);
    repeat (4) begin
      @(negedge sck);
      check("no_extra_frame_busy", busy, 0);
      check("no_extra_frame_cs", cs, 1);
    end

    // Back-to-back: second request in the cycle after busy falls.
    run_frame(1'b0, 2, 8'h03, 8'h81, 1'b0, 1'b0);
    run_frame(1'b1, 1, 8'h7E, 8'hC3, 1'b0, 1'b0);

    // Randomized frames, including dev_sel = 3 (no such device).
    for (int i = 0; i < 6; i++) begin
      run_frame(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    // Asynchronous reset at bit 20 of a frame.
    broadcast = 1'b1;
    address   = 8'hFF;
    data      = 8'hFF;
    start     = 1'b1;
    @(posedge sck);
    #1;
    start = 1'b0;
    rises = 0;
    pclk  = 1'b0;
    for (int k = 0; k < BUSY_LEN && rises < 20; k++) begin
      @(negedge sck);
      if (spi_clk && !pclk) rises++;
      pclk = spi_clk;
    end
    check("reached_bit_20", rises, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs", cs, 1);
    check("abort_spi_clk", spi_clk, 0);
    check("abort_mosi", mosi, 0);
    check("abort_busy", busy, 0);
    check("abort_finish", finish, 0);
    @(negedge sck);
    rst_n = 1'b1;
    @(negedge sck);
    run_frame(1'b0, 1, 8'h0B, 8'h07, 1'b0, 1'b0);

    repeat (3) @(negedge sck);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
